// File: rtl/regfile_dump_pkg.sv
// Shared types and constants for the register-file dump reader.
// The SUM state is only reachable when REGDUMP_CHECKSUM_EN is defined.
package regfile_dump_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    READ = 3'd1,
    HOLD = 3'd2,
    SUM  = 3'd3,
    FIN  = 3'd4
  } state_t;

  // Beats in a dump: the 5-bit subtraction wraps, so the result is 1..32.
  function automatic logic [REG_ADDR_W:0] beat_count(
    input logic [REG_ADDR_W-1:0] first,
    input logic [REG_ADDR_W-1:0] last
  );
    logic [REG_ADDR_W-1:0] span;
    span = last - first;
    return {1'b0, span} + {{REG_ADDR_W{1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/regfile_dump_reader_if.sv
// Beat stream carrying (address, data, last) out of the dump reader.
// A beat transfers on a posedge where out_valid && out_ready; the source keeps
// out_valid, out_addr, out_data and out_last stable until that edge.
interface regfile_dump_reader_if #(
  parameter int WIDTH = 32
);
  import regfile_dump_pkg::*;

  logic                  out_valid;
  logic                  out_ready;
  logic [REG_ADDR_W-1:0] out_addr;
  logic [WIDTH-1:0]      out_data;
  logic                  out_last;

  modport master (
    output out_valid,
    output out_addr,
    output out_data,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_addr,
    input  out_data,
    input  out_last,
    output out_ready
  );

endinterface

// File: rtl/regfile_dump_reader.sv
// Walks an address range through one register-file read port and streams
// (address, data) beats. Optional trailing XOR beat: REGDUMP_CHECKSUM_EN.
module regfile_dump_reader
  import regfile_dump_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int NUM_REGS = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [REG_ADDR_W-1:0] first_addr,
  input  logic [REG_ADDR_W-1:0] last_addr,
  output logic                  busy,
  output logic                  done,
  output logic [REG_ADDR_W-1:0] ra,
  input  logic [WIDTH-1:0]      rd,
  regfile_dump_reader_if.master dump,
  output state_t                state_dbg
);

  state_t                state_q, state_d;
  logic [REG_ADDR_W-1:0] ra_q, ra_d;
  logic [REG_ADDR_W-1:0] last_q, last_d;
  logic                  busy_q, busy_d;
  logic                  valid_q, valid_d;
  logic [REG_ADDR_W-1:0] addr_q, addr_d;
  logic [WIDTH-1:0]      data_q, data_d;
  logic                  olast_q, olast_d;
  logic                  at_last;
`ifdef REGDUMP_CHECKSUM_EN
  logic [WIDTH-1:0]      csum_q, csum_d;
`endif

  // ra is not advanced while a beat is held, so this also marks the held beat.
  assign at_last = (ra_q == last_q);

  always_comb begin
    state_d = state_q;
    ra_d    = ra_q;
    last_d  = last_q;
    busy_d  = busy_q;
    valid_d = valid_q;
    addr_d  = addr_q;
    data_d  = data_q;
    olast_d = olast_q;
`ifdef REGDUMP_CHECKSUM_EN
    csum_d  = csum_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          ra_d    = first_addr;
          last_d  = last_addr;
          busy_d  = 1'b1;
`ifdef REGDUMP_CHECKSUM_EN
          csum_d  = '0;
`endif
          state_d = READ;
        end
      end
      READ: begin
        data_d  = rd;
        addr_d  = ra_q;
        valid_d = 1'b1;
`ifdef REGDUMP_CHECKSUM_EN
        olast_d = 1'b0;
        csum_d  = csum_q ^ rd;
`else
        olast_d = at_last;
`endif
        state_d = HOLD;
      end
      HOLD: begin
        if (dump.out_ready) begin
          valid_d = 1'b0;
          if (at_last) begin
`ifdef REGDUMP_CHECKSUM_EN
            // Checksum beat follows straight on; its data already covers every register beat.
            valid_d = 1'b1;
            addr_d  = '0;
            data_d  = csum_q;
            olast_d = 1'b1;
            state_d = SUM;
`else
            olast_d = 1'b0;
            state_d = FIN;
`endif
          end else begin
            ra_d    = (ra_q == REG_ADDR_W'(NUM_REGS - 1)) ? '0 : ra_q + 5'd1;
            state_d = READ;
          end
        end
      end
      SUM: begin
`ifdef REGDUMP_CHECKSUM_EN
        if (dump.out_ready) begin
          valid_d = 1'b0;
          olast_d = 1'b0;
          state_d = FIN;
        end
`else
        state_d = IDLE;
`endif
      end
      FIN: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ra_q    <= '0;
      last_q  <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      olast_q <= 1'b0;
`ifdef REGDUMP_CHECKSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      ra_q    <= ra_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      olast_q <= olast_d;
`ifdef REGDUMP_CHECKSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

  assign busy           = busy_q;
  assign done           = (state_q == FIN);
  assign ra             = ra_q;
  assign dump.out_valid = valid_q;
  assign dump.out_addr  = addr_q;
  assign dump.out_data  = data_q;
  assign dump.out_last  = olast_q;
  assign state_dbg      = state_q;

endmodule
